// File: rtl/race_state_sequencer.sv
// race_state_sequencer
//   Race-flow controller driving the shared 3-bit state bus seen by every
//   per-car physics engine. Walks IDLE -> SETTING -> COUNTDOWN -> RACING
//   <-> PAUSE -> FINISH from debounced button pulses and checkpoint lap
//   pulses, runs the start countdown, counts laps and flags completion.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   start_pulse  in   1   one-cycle start/confirm press
//   pause_pulse  in   1   one-cycle pause/resume press
//   lap_pulse    in   1   one-cycle pulse when the lead car crosses the line
//   state        out  3   IDLE=0 SETTING=1 COUNTDOWN=3 RACING=4 PAUSE=5 FINISH=6
//   countdown    out  3   remaining countdown value, 0 outside COUNTDOWN
//   lap_count    out  4   completed laps
//   finish_flag  out  1   one-cycle pulse on entry to FINISH
//   race_time    out  16  elapsed RACING ticks (timer build only, else 0)
//
// Configuration
//   RACE_TIMER_EN  when defined, the tick divider also runs in RACING and
//                  race_time counts divider wraps (saturating). When not
//                  defined, race_time is tied to 0 and no timer logic exists.

module race_state_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int COUNT_START = 3,
  parameter int LAPS        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        pause_pulse,
  input  logic        lap_pulse,
  output logic [2:0]  state,
  output logic [2:0]  countdown,
  output logic [3:0]  lap_count,
  output logic        finish_flag,
  output logic [15:0] race_time
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

  localparam int              DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [2:0]      CNT_LOAD  = 3'(COUNT_START);
  localparam logic [3:0]      LAST_LAP  = 4'(LAPS - 1);

  state_t           state_q;
  logic [DIV_W-1:0] divider;
  logic [3:0]       lap_next;
  logic             div_wrap;

  assign state    = state_q;
  assign div_wrap = (divider == DIV_LAST);
  assign lap_next = (lap_count == 4'd15) ? lap_count : lap_count + 4'd1;

`ifndef RACE_TIMER_EN
  assign race_time = 16'd0;
`endif

  // Single-process FSM. Every state change also clears the divider so each
  // state starts its tick count from zero; the later divider assignment in
  // the RACING branch deliberately overrides the timer update on a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      countdown   <= 3'd0;
      lap_count   <= 4'd0;
      finish_flag <= 1'b0;
      divider     <= '0;
`ifdef RACE_TIMER_EN
      race_time   <= 16'd0;
`endif
    end else begin
      finish_flag <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_pulse) begin
            state_q <= SETTING;
            divider <= '0;
          end
        end
        SETTING: begin
          if (start_pulse) begin
            state_q   <= COUNTDOWN;
            countdown <= CNT_LOAD;
            lap_count <= 4'd0;
            divider   <= '0;
`ifdef RACE_TIMER_EN
            race_time <= 16'd0;
`endif
          end
        end
        COUNTDOWN: begin
          if (div_wrap) begin
            divider <= '0;
            if (countdown == 3'd1) begin
              state_q   <= RACING;
              countdown <= 3'd0;
            end else begin
              countdown <= countdown - 3'd1;
            end
          end else begin
            divider <= divider + 1'b1;
          end
        end
        RACING: begin
`ifdef RACE_TIMER_EN
          if (div_wrap) begin
            divider <= '0;
            if (race_time != 16'hFFFF) race_time <= race_time + 16'd1;
          end else begin
            divider <= divider + 1'b1;
          end
`endif
          if (lap_pulse) lap_count <= lap_next;
          // The lap is credited before pause is considered, so a finishing
          // lap wins over a simultaneous pause press.
          if (lap_pulse && lap_count == LAST_LAP) begin
            state_q     <= FINISH;
            finish_flag <= 1'b1;
            divider     <= '0;
          end else if (pause_pulse) begin
            state_q <= PAUSE;
            divider <= '0;
          end
        end
        PAUSE: begin
          if (pause_pulse) begin
            state_q <= RACING;
            divider <= '0;
          end
        end
        FINISH: begin
          if (start_pulse) begin
            state_q   <= IDLE;
            lap_count <= 4'd0;
            divider   <= '0;
`ifdef RACE_TIMER_EN
            race_time <= 16'd0;
`endif
          end
        end
        default: begin
          // Codes 2 and 7 are never produced; recover to IDLE if seen.
          state_q   <= IDLE;
          countdown <= 3'd0;
          divider   <= '0;
        end
      endcase
    end
  end

endmodule
